// File: rtl/fb_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_access_arbiter_if
// Desc     : Scan-out, write-port and RAM-side signal bundle of the
//            frame-buffer access arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_access_arbiter_if #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic                pix_en;
    logic [9:0]          addrh;
    logic [8:0]          addrv;
    logic [7:0]          colour_in;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_data;
    logic                wr_drop;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [7:0]          ram_wdata;
    logic [7:0]          ram_rdata;
    logic [c_lvl_w-1:0]  fifo_level;

    // master: VGA timing, write source and RAM; slave: the arbiter
    modport master (
        output pix_en, addrh, addrv, wr_valid, wr_addr, wr_data, ram_rdata,
        input  colour_in, wr_ready, wr_drop, ram_addr, ram_we, ram_wdata, fifo_level
    );

    modport slave (
        input  pix_en, addrh, addrv, wr_valid, wr_addr, wr_data, ram_rdata,
        output colour_in, wr_ready, wr_drop, ram_addr, ram_we, ram_wdata, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/fb_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_access_arbiter
// Desc     : Shares a single-port pixel RAM between VGA scan-out reads and a
//            FIFO-buffered write port. Optional macro FB_STARVE_GUARD_EN adds a
//            write-starvation guard that steals a display slot.
// Revision : 1.0 - initial release
// ============================================================================
module fb_access_arbiter #(
    parameter int         IMG_W      = 225,
    parameter int         IMG_H      = 225,
    parameter int         ADDR_W     = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] BG_COLOUR  = 8'hFF,
    parameter int         STARVE_MAX = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fb_access_arbiter_if.slave  bus
);
    localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int                 c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full  = c_lvl_w'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  c_img_w = ADDR_W'(IMG_W);
    localparam logic [ADDR_W:0]    c_npix  = (ADDR_W + 1)'(IMG_W * IMG_H);

    // What the read pipe delivers to the colour register three cycles later
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_RAM  = 2'd1,
        TAG_BG   = 2'd2,
        TAG_HOLD = 2'd3
    } tag_t;

    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [7:0]         r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               r_run;
    tag_t               r_tag1;
    tag_t               r_tag2;
    tag_t               w_tag;
    logic [7:0]         r_colour;
    logic [7:0]         r_ram_wdata;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_we;
    logic               r_drop;

    logic               w_in_win;
    logic               w_disp_req;
    logic               w_force;
    logic               w_disp;
    logic               w_pop;
    logic               w_push;
    logic               w_empty;
    logic               w_full;
    logic               w_ready;
    logic               w_head_oor;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_head_addr;

    assign w_in_win    = (bus.addrh < 10'(IMG_W)) && (bus.addrv < 9'(IMG_H));
    assign w_idx       = ADDR_W'(bus.addrv) * c_img_w + ADDR_W'(bus.addrh);
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_full);
    // Ready comes from the level register only, so a full FIFO never falls through
    assign w_ready     = r_run && !w_full;
    assign w_push      = bus.wr_valid && w_ready;
    assign w_disp_req  = bus.pix_en && w_in_win;
    assign w_disp      = w_disp_req && !w_force;
    assign w_pop       = !w_disp && !w_empty;
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_oor  = ({1'b0, w_head_addr} >= c_npix);

`ifdef FB_STARVE_GUARD_EN
    localparam int                 c_stv_w   = $clog2(STARVE_MAX + 1);
    localparam logic [c_stv_w-1:0] c_stv_max = c_stv_w'(STARVE_MAX);

    logic [c_stv_w-1:0] r_starve;

    assign w_force = w_disp_req && !w_empty && (r_starve >= c_stv_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_pop) begin
            r_starve <= '0;
        end else if (w_full && w_disp && (r_starve != c_stv_max)) begin
            r_starve <= r_starve + c_stv_w'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_tag = TAG_NONE;
        if (bus.pix_en) begin
            if (w_force) begin
                w_tag = TAG_HOLD;
            end else if (w_in_win) begin
                w_tag = TAG_RAM;
            end else begin
                w_tag = TAG_BG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.wr_addr;
            r_fifo_data[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            r_drop   <= 1'b0;
            if (w_disp) begin
                r_ram_addr <= w_idx;
            end else if (w_pop) begin
                // Out-of-range entries are consumed without touching the RAM
                if (w_head_oor) begin
                    r_drop <= 1'b1;
                end else begin
                    r_ram_addr  <= w_head_addr;
                    r_ram_wdata <= r_fifo_data[r_rd_ptr];
                    r_ram_we    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1   <= TAG_NONE;
            r_tag2   <= TAG_NONE;
            r_colour <= '0;
        end else begin
            r_tag1 <= w_tag;
            r_tag2 <= r_tag1;
            case (r_tag2)
                TAG_RAM: r_colour <= bus.ram_rdata;
                TAG_BG:  r_colour <= BG_COLOUR;
                default: r_colour <= r_colour;
            endcase
        end
    end

    assign bus.colour_in  = r_colour;
    assign bus.wr_ready   = w_ready;
    assign bus.wr_drop    = r_drop;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fb_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_access_arbiter
// Desc     : Randomized self-checking bench for fb_access_arbiter against a
//            queue-based behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_access_arbiter;
    localparam int IMG_W      = 225;
    localparam int IMG_H      = 225;
    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 8;
    localparam int NPIX       = IMG_W * IMG_H;
    localparam logic [7:0] BG = 8'hFF;

    logic clk;
    logic rst_n;

    fb_access_arbiter_if #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    fb_access_arbiter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
        .BG_COLOUR(BG), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents are mem[i] = i[7:0]; writes are checked on the bus, not stored
    always @(posedge clk) bus.ram_rdata <= bus.ram_addr[7:0];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         m_q[$];
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wdata;
    logic        e_drop;
    logic [7:0]  e_colour;
    bit          m_run;
    logic [7:0]  due_val[4];
    bit          due_set[4];
    int          cyc;
    int          m_starve;

    task automatic model_reset();
        m_q.delete();
        e_addr = '0; e_we = 1'b0; e_wdata = '0; e_drop = 1'b0; e_colour = '0;
        m_run = 1'b0; m_starve = 0;
        for (int i = 0; i < 4; i++) due_set[i] = 1'b0;
    endtask

    task automatic check_outputs();
        if (due_set[cyc % 4]) begin
            e_colour = due_val[cyc % 4];
            due_set[cyc % 4] = 1'b0;
        end
        check_value("colour_in", bus.colour_in, e_colour);
        check_value("ram_addr", bus.ram_addr, e_addr);
        check_value("ram_we", bus.ram_we, e_we);
        check_value("ram_wdata", bus.ram_wdata, e_wdata);
        check_value("wr_drop", bus.wr_drop, e_drop);
        check_value("fifo_level", bus.fifo_level, m_q.size());
        check_value("wr_ready", bus.wr_ready, (m_run && m_q.size() != FIFO_DEPTH) ? 1 : 0);
    endtask

    // Drives one cycle of inputs and advances the model to the state after the next edge
    task automatic apply_and_step(input bit pix, input int h, input int v,
                                  input bit wv, input int wa, input int wd);
        bit  in_win;
        bit  ready;
        bit  disp;
        bit  steal;
        bit  was_full;
        bit  popped;
        int  idx;
        wr_t e;
        bus.pix_en   = pix;
        bus.addrh    = 10'(h);
        bus.addrv    = 9'(v);
        bus.wr_valid = wv;
        bus.wr_addr  = 16'(wa);
        bus.wr_data  = 8'(wd);
        in_win   = (h < IMG_W) && (v < IMG_H);
        idx      = v * IMG_W + h;
        ready    = m_run && (m_q.size() != FIFO_DEPTH);
        disp     = pix && in_win;
        steal    = 1'b0;
        was_full = (m_q.size() == FIFO_DEPTH);
        popped   = 1'b0;
`ifdef FB_STARVE_GUARD_EN
        if (disp && m_starve >= STARVE_MAX && m_q.size() > 0) steal = 1'b1;
`endif
        e_we   = 1'b0;
        e_drop = 1'b0;
        if (disp && !steal) begin
            e_addr = 16'(idx);
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            popped = 1'b1;
            if (int'(e.addr) >= NPIX) begin
                e_drop = 1'b1;
            end else begin
                e_addr  = e.addr;
                e_wdata = e.data;
                e_we    = 1'b1;
            end
        end
`ifdef FB_STARVE_GUARD_EN
        if (popped) m_starve = 0;
        else if (was_full && disp && m_starve < STARVE_MAX) m_starve++;
`endif
        if (wv && ready) m_q.push_back({16'(wa), 8'(wd)});
        if (pix && !steal) begin
            due_val[(cyc + 3) % 4] = in_win ? idx[7:0] : BG;
            due_set[(cyc + 3) % 4] = 1'b1;
        end
        m_run = 1'b1;
        cyc++;
    endtask

    task automatic drive_cycle(input bit pix, input int h, input int v,
                               input bit wv, input int wa, input int wd);
        @(negedge clk);
        check_outputs();
        apply_and_step(pix, h, v, wv, wa, wd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pix_en = 1'b0; bus.addrh = '0; bus.addrv = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        #1;
        check_value("rst_colour", bus.colour_in, 0);
        check_value("rst_ram_addr", bus.ram_addr, 0);
        check_value("rst_ram_we", bus.ram_we, 0);
        check_value("rst_ram_wdata", bus.ram_wdata, 0);
        check_value("rst_wr_drop", bus.wr_drop, 0);
        check_value("rst_level", bus.fifo_level, 0);
        check_value("rst_wr_ready", bus.wr_ready, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply_and_step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  drops;
        bit  seen_full;
        bit  prev_pix;
        bit  pix;
        int  wa;
        rst_n = 1'b0;
        cyc   = 0;
        @(negedge clk);
        do_reset();

        // Read latency: 2*225+10 = 460 -> colour 8'hCC three cycles later
        drive_cycle(1, 10, 2, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_value("lat_ram_addr", bus.ram_addr, 460);
        drive_cycle(0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_value("lat_colour", bus.colour_in, 8'hCC);

        // Window edge: last pixel, then one past the right edge
        drive_cycle(1, 224, 224, 0, 0, 0);
        drive_cycle(1, 225, 224, 0, 0, 0);
        check_value("edge_ram_addr", bus.ram_addr, 50624);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_value("edge_no_access", bus.ram_addr, 50624);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_value("edge_last_colour", bus.colour_in, 8'hC0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        check_value("edge_bg_colour", bus.colour_in, BG);

        // Backpressure: writes every cycle while the display takes every other slot
        seen_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(i % 2 == 0, 5 + i, 5, 1, 200 + i, i);
            if (bus.wr_ready === 1'b0) seen_full = 1'b1;
        end
        check_value("bp_full_seen", seen_full, 1);
        repeat (8) drive_cycle(0, 0, 0, 0, 0, 0);

        // Writes to 100..103 under an active scan
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i % 2 == 0, 20 + i, 3, i < 4, 100 + i, 8'h40 + i);
        end
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 0);

        // Out-of-range write is consumed with a single drop pulse
        drops = 0;
        drive_cycle(0, 0, 0, 1, NPIX, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0, 0, 0, 0);
            if (bus.wr_drop === 1'b1) drops++;
        end
        check_value("drop_pulses", drops, 1);

        // Reset asserted mid-drain at level 3
        for (int k = 0; k < 20; k++) begin
            drive_cycle(k % 2 == 0, 7, 7, 1, 300 + k, k);
            if (m_q.size() == 3) break;
        end
        @(negedge clk);
        check_value("pre_rst_level", bus.fifo_level, 3);
        do_reset();

        // Randomized traffic; PIX_EN never high on two consecutive cycles
        prev_pix = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            pix = !prev_pix && ($urandom_range(0, 3) != 0);
            wa  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NPIX, 65535))
                                              : int'($urandom_range(0, NPIX - 1));
            drive_cycle(pix, int'($urandom_range(0, 239)), int'($urandom_range(0, 239)),
                        $urandom_range(0, 1) == 1, wa, int'($urandom_range(0, 255)));
            prev_pix = pix;
        end
        repeat (12) drive_cycle(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
